interlock_card_gen: RTL and testbench

- Parametrised successor to the single-purpose interlock card for power-supply (PS) control.
- Generalises the fixed 7-input status NOR to N_CH maskable, debounced, latched fault channels with first-fault capture and operator acknowledge.
- Replaces the fixed 256/3840-sample shift registers with tick-driven counters inside an explicit sequencing FSM.
- Sits between the field-input conditioning logic and the PS-enable / front-panel indicator drivers.

---
 rtl/interlock_pkg.sv | 17 +
 rtl/fault_channel.sv | 45 ++++
 rtl/interlock_card_gen.sv | 181 ++++++++++++++++++
 tb/tb_interlock_card_gen.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interlock_pkg.sv
// Shared types and defaults for the parametrised PS interlock card.
package interlock_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMING = 3'd1,
    WARMUP = 3'd2,
    READY  = 3'd3,
    TRIP   = 3'd4
  } state_t;

  localparam int DEF_PERMIT_DLY = 256;
  localparam int DEF_READY_DLY  = 3840;
  localparam int DEF_DEB_TICKS  = 4;
  localparam int SYNC_DEPTH     = 2;

endpackage

// File: rtl/fault_channel.sv
// One fault channel: input synchroniser, tick-based debounce and ack-cleared latch.
module fault_channel
  import interlock_pkg::*;
#(
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic fault_raw,
  input  logic mask,
  input  logic ack_s,
  output logic latched,
  output logic set_pulse
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  fault_s;
  logic [3:0]            deb_cnt;
  logic                  valid;

  assign fault_s   = sync_q[SYNC_DEPTH-1];
  assign valid     = (deb_cnt == 4'(DEB_TICKS));
  assign set_pulse = valid & ~mask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      deb_cnt <= '0;
      latched <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], fault_raw};
      if (!fault_s)
        deb_cnt <= '0;
      else if (tick && !valid)
        deb_cnt <= deb_cnt + 4'd1;
      // a fresh set always wins over a concurrent acknowledge
      if (set_pulse)
        latched <= 1'b1;
      else if (ack_s && !fault_s)
        latched <= 1'b0;
    end
  end

endmodule

// File: rtl/interlock_card_gen.sv
// PS interlock card: per-channel fault latching, first-fault capture and the
// IDLE/ARMING/WARMUP/READY/TRIP start-up sequencer with registered indicator outputs.
module interlock_card_gen
  import interlock_pkg::*;
#(
  parameter int N_CH       = 8,
  parameter int CNT_W      = 16,
  parameter int PERMIT_DLY = DEF_PERMIT_DLY,
  parameter int READY_DLY  = DEF_READY_DLY,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  localparam int FF_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tick,
  input  logic [N_CH-1:0] fault_in,
  input  logic [N_CH-1:0] fault_mask,
  input  logic            ack,
  input  logic            ps_request,
  input  logic            fan_on,
  input  logic            g1_not_ok,
  input  logic            i_high,
  input  logic            u_low,
  output logic            not_alarm,
  output logic [N_CH-1:0] fault_latched,
  output logic [FF_W-1:0] first_fault,
  output logic            first_valid,
  output logic            permit,
  output logic            ps_delay,
  output logic            not_ps_ok,
  output logic            i_high_n,
  output logic            u_low_n,
  output logic [2:0]      state_o
);

  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W must be 1..32");
  end
  if (longint'(PERMIT_DLY) >= (longint'(1) << CNT_W) || PERMIT_DLY < 0) begin : g_bad_permit
    $error("PERMIT_DLY does not fit in CNT_W bits");
  end
  if (longint'(READY_DLY) >= (longint'(1) << CNT_W) || READY_DLY < 0) begin : g_bad_ready
    $error("READY_DLY does not fit in CNT_W bits");
  end
  if (DEB_TICKS < 1 || DEB_TICKS > 15) begin : g_bad_deb
    $error("DEB_TICKS must be 1..15");
  end

  logic [4:0] ctl_sync [SYNC_DEPTH];
  logic       ack_s, u_low_s, i_high_s, g1_s, fan_on_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_DEPTH; i++) ctl_sync[i] <= '0;
    end else begin
      ctl_sync[0] <= {ack, u_low, i_high, g1_not_ok, fan_on};
      for (int i = 1; i < SYNC_DEPTH; i++) ctl_sync[i] <= ctl_sync[i-1];
    end
  end

  assign {ack_s, u_low_s, i_high_s, g1_s, fan_on_s} = ctl_sync[SYNC_DEPTH-1];

  logic [N_CH-1:0] set_vec;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    fault_channel #(.DEB_TICKS(DEB_TICKS)) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .fault_raw (fault_in[c]),
      .mask      (fault_mask[c]),
      .ack_s     (ack_s),
      .latched   (fault_latched[c]),
      .set_pulse (set_vec[c])
    );
  end

  logic [FF_W-1:0] first_idx;

  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (set_vec[i]) first_idx = FF_W'(i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_fault <= '0;
      first_valid <= 1'b0;
    end else if (|set_vec && !(|fault_latched)) begin
      first_fault <= first_idx;
      first_valid <= 1'b1;
    end else if (!(|fault_latched)) begin
      first_valid <= 1'b0;
    end
  end

  // a masked channel that is still latched no longer raises the alarm
  assign not_alarm = ~|(fault_latched & ~fault_mask);
  assign permit    = not_alarm & ~fan_on_s & ~g1_s;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign cnt_inc = cnt + CNT_W'(tick);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (ps_request && permit) begin
          state_nxt = ARMING;
          cnt_nxt   = '0;
        end
      end
      ARMING: begin
        cnt_nxt = '0;
        if (!ps_request)                         state_nxt = IDLE;
        else if (!permit)                        state_nxt = TRIP;
        else if (cnt_inc == CNT_W'(PERMIT_DLY))  state_nxt = WARMUP;
        else                                     cnt_nxt   = cnt_inc;
      end
      WARMUP: begin
        cnt_nxt = '0;
        if (!ps_request)                         state_nxt = IDLE;
        else if (!permit)                        state_nxt = TRIP;
        else if (cnt_inc == CNT_W'(READY_DLY))   state_nxt = READY;
        else                                     cnt_nxt   = cnt_inc;
      end
      READY: begin
        if (!ps_request)  state_nxt = IDLE;
        else if (!permit) state_nxt = TRIP;
      end
      TRIP: begin
        if (!ps_request && not_alarm) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  logic ps_delay_d, not_ps_ok_d, i_high_n_d, u_low_n_d, powered;

  always_comb begin
    powered     = (state == WARMUP) || (state == READY);
    ps_delay_d  = (state == READY);
    not_ps_ok_d = (state != READY);
    i_high_n_d  = ~(i_high_s & powered);
    u_low_n_d   = ~(u_low_s & powered);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps_delay  <= 1'b0;
      not_ps_ok <= 1'b1;
      i_high_n  <= 1'b1;
      u_low_n   <= 1'b1;
    end else begin
      ps_delay  <= ps_delay_d;
      not_ps_ok <= not_ps_ok_d;
      i_high_n  <= i_high_n_d;
      u_low_n   <= u_low_n_d;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_interlock_card_gen.sv
// Bench for interlock_card_gen: state-transition scoreboard plus directed latch/output checks.
module tb_interlock_card_gen;

  localparam int N_CH       = 4;
  localparam int PERMIT_DLY = 4;
  localparam int READY_DLY  = 8;
  localparam int DEB_TICKS  = 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMING = 3'd1;
  localparam logic [2:0] S_WARMUP = 3'd2;
  localparam logic [2:0] S_READY  = 3'd3;
  localparam logic [2:0] S_TRIP   = 3'd4;

  logic            clk = 1'b0;
  logic            reset, tick, ack, ps_request, fan_on, g1_not_ok, i_high, u_low;
  logic [N_CH-1:0] fault_in, fault_mask;
  logic            not_alarm, first_valid, permit, ps_delay, not_ps_ok, i_high_n, u_low_n;
  logic [N_CH-1:0] fault_latched;
  logic [1:0]      first_fault;
  logic [2:0]      state_o;

  interlock_card_gen #(
    .N_CH(N_CH), .CNT_W(16), .PERMIT_DLY(PERMIT_DLY),
    .READY_DLY(READY_DLY), .DEB_TICKS(DEB_TICKS)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .fault_in(fault_in), .fault_mask(fault_mask),
    .ack(ack), .ps_request(ps_request), .fan_on(fan_on), .g1_not_ok(g1_not_ok),
    .i_high(i_high), .u_low(u_low), .not_alarm(not_alarm), .fault_latched(fault_latched),
    .first_fault(first_fault), .first_valid(first_valid), .permit(permit),
    .ps_delay(ps_delay), .not_ps_ok(not_ps_ok), .i_high_n(i_high_n), .u_low_n(u_low_n),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] st;
    int         dwell;
  } sb_t;

  sb_t        exp_q[$];
  sb_t        e;
  logic [2:0] prev_st   = S_IDLE;
  int         cyc       = 0;
  int         last_chg  = 0;

  task automatic push(input logic [2:0] st, input int dwell);
    sb_t x;
    x.st    = st;
    x.dwell = dwell;
    exp_q.push_back(x);
  endtask

  // every observed state change must match the next expected one, with its dwell time
  always @(negedge clk) begin
    cyc++;
    if (state_o !== prev_st) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(state_o), 32'(prev_st));
      end else begin
        e = exp_q.pop_front();
        chk("sb_state", 32'(state_o), 32'(e.st));
        if (e.dwell >= 0) chk("sb_dwell", 32'(cyc - last_chg), 32'(e.dwell));
      end
      prev_st  = state_o;
      last_chg = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget,
                            output int n);
    n = 0;
    while (state_o !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(state_o), 32'(target));
  endtask

  int n;

  initial begin
    reset = 1'b0; tick = 1'b1; ack = 1'b0; ps_request = 1'b0; fan_on = 1'b0;
    g1_not_ok = 1'b0; i_high = 1'b0; u_low = 1'b0; fault_in = '0; fault_mask = '0;
    step(2);
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_not_alarm", 32'(not_alarm), 32'd1);
    chk("rst_ps_delay", 32'(ps_delay), 32'd0);
    chk("rst_not_ps_ok", 32'(not_ps_ok), 32'd1);
    chk("rst_i_high_n", 32'(i_high_n), 32'd1);
    chk("rst_u_low_n", 32'(u_low_n), 32'd1);
    chk("rst_latched", 32'(fault_latched), 32'd0);
    chk("rst_first_valid", 32'(first_valid), 32'd0);
    reset = 1'b1;
    step(3);

    // normal start-up, with i_high asserted to check the monitor gating
    i_high = 1'b1;
    step(4);
    chk("ihigh_idle", 32'(i_high_n), 32'd1);
    push(S_ARMING, -1); push(S_WARMUP, PERMIT_DLY); push(S_READY, READY_DLY);
    ps_request = 1'b1;
    wait_state("reach_warmup", S_WARMUP, 20, n);
    step(1);
    chk("ihigh_warmup", 32'(i_high_n), 32'd0);
    wait_state("reach_ready", S_READY, 30, n);
    chk("ps_delay_lag", 32'(ps_delay), 32'd0);
    step(1);
    chk("ps_delay_ready", 32'(ps_delay), 32'd1);
    chk("not_ps_ok_ready", 32'(not_ps_ok), 32'd0);
    chk("u_low_n_ready", 32'(u_low_n), 32'd1);
    i_high = 1'b0;

    // trip from READY, acknowledge with and without the fault still present
    push(S_TRIP, -1);
    fault_in[1] = 1'b1;
    wait_state("reach_trip", S_TRIP, 20, n);
    chk("trip_latency", 32'(n), 32'(2 + DEB_TICKS + 2));
    chk("trip_first_fault", 32'(first_fault), 32'd1);
    chk("trip_first_valid", 32'(first_valid), 32'd1);
    chk("trip_latched", 32'(fault_latched), 32'b0010);
    chk("trip_not_alarm", 32'(not_alarm), 32'd0);
    ack = 1'b1;
    step(4);
    chk("ack_held", 32'(fault_latched), 32'b0010);
    ack = 1'b0;
    fault_in[1] = 1'b0;
    step(4);
    ack = 1'b1;
    step(4);
    chk("ack_cleared", 32'(fault_latched), 32'd0);
    chk("ack_first_valid", 32'(first_valid), 32'd0);
    chk("ack_not_alarm", 32'(not_alarm), 32'd1);
    ack = 1'b0;
    push(S_IDLE, -1);
    ps_request = 1'b0;
    wait_state("trip_exit", S_IDLE, 10, n);

    // debounce: one-tick glitch ignored, three-tick pulse latched
    fault_in[2] = 1'b1;
    step(1);
    fault_in[2] = 1'b0;
    step(8);
    chk("glitch_latched", 32'(fault_latched), 32'd0);
    chk("glitch_not_alarm", 32'(not_alarm), 32'd1);
    fault_in[2] = 1'b1;
    step(3);
    fault_in[2] = 1'b0;
    step(6);
    chk("pulse_latched", 32'(fault_latched), 32'b0100);
    chk("pulse_not_alarm", 32'(not_alarm), 32'd0);
    chk("pulse_first_fault", 32'(first_fault), 32'd2);
    ack = 1'b1;
    step(4);
    ack = 1'b0;
    step(2);
    chk("pulse_cleared", 32'(fault_latched), 32'd0);

    // simultaneous faults: lowest index wins
    fault_in = 4'b1001;
    step(8);
    chk("simul_first_fault", 32'(first_fault), 32'd0);
    chk("simul_latched", 32'(fault_latched), 32'b1001);
    fault_in = '0;
    step(4);
    ack = 1'b1;
    step(4);
    ack = 1'b0;
    step(2);
    chk("simul_cleared", 32'(fault_latched), 32'd0);

    // masked channel neither latches nor blocks start-up
    fault_mask = 4'b0010;
    fault_in[1] = 1'b1;
    step(8);
    chk("mask_latched", 32'(fault_latched), 32'd0);
    push(S_ARMING, -1); push(S_WARMUP, PERMIT_DLY); push(S_READY, READY_DLY);
    ps_request = 1'b1;
    wait_state("mask_ready", S_READY, 40, n);
    chk("mask_not_alarm", 32'(not_alarm), 32'd1);
    push(S_IDLE, -1);
    ps_request = 1'b0;
    wait_state("mask_idle", S_IDLE, 10, n);
    fault_in[1] = 1'b0;
    step(6);
    fault_mask = '0;

    // masking a latched channel keeps the latch but clears the alarm
    fault_in[0] = 1'b1;
    step(8);
    chk("late_mask_latch", 32'(fault_latched), 32'b0001);
    fault_mask = 4'b0001;
    step(1);
    chk("late_mask_alarm", 32'(not_alarm), 32'd1);
    chk("late_mask_kept", 32'(fault_latched), 32'b0001);
    fault_in[0] = 1'b0;
    step(6);

    // asynchronous reset in the middle of WARMUP
    push(S_ARMING, -1); push(S_WARMUP, PERMIT_DLY);
    ps_request = 1'b1;
    i_high = 1'b1;
    wait_state("pre_rst_warmup", S_WARMUP, 20, n);
    step(3);
    chk("pre_rst_i_high_n", 32'(i_high_n), 32'd0);
    push(S_IDLE, -1);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(state_o), 32'(S_IDLE));
    chk("arst_latched", 32'(fault_latched), 32'd0);
    chk("arst_first_valid", 32'(first_valid), 32'd0);
    chk("arst_i_high_n", 32'(i_high_n), 32'd1);
    chk("arst_not_ps_ok", 32'(not_ps_ok), 32'd1);
    chk("arst_ps_delay", 32'(ps_delay), 32'd0);
    chk("arst_not_alarm", 32'(not_alarm), 32'd1);
    step(2);
    ps_request = 1'b0;
    i_high = 1'b0;
    fault_mask = '0;
    reset = 1'b1;
    step(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
